// File: rtl/led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_driver
// Brief    : Glitch-free 8-channel LED PWM with period-synchronised commands
//            and a full-brightness activity flash on newly lit LEDs.
// Revision : 1.0 - initial release
// ============================================================================
module led_pwm_driver #(
    parameter int PRESCALE      = 195,
    parameter int FLASH_PERIODS = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] led_cmd,
    input  logic [7:0] duty,
    output logic [7:0] led,
    output logic       period_strobe
);

    localparam int                c_PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(PRESCALE - 1);
    localparam logic [7:0]        c_FLASH_LOAD = 8'(FLASH_PERIODS);

    logic [c_PRESC_W-1:0] r_presc_cnt;
    logic [7:0]           r_pwm_cnt;
    logic [7:0]           r_shadow;
    logic [7:0]           r_duty_q;
    logic [7:0]           r_flash_cnt [8];
    logic [7:0]           r_led;
    logic                 r_period_strobe;

    logic                 w_tick;
    logic                 w_boundary;
    logic [7:0]           w_flash_next [8];
    logic [7:0]           w_led_next;

    assign w_tick     = (r_presc_cnt == c_PRESC_MAX);
    assign w_boundary = w_tick && (r_pwm_cnt == 8'hFF);

    // Flash reload/decay is only committed at a period boundary; the LED
    // decision always uses the values latched before the current edge.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_flash_next[i] = r_flash_cnt[i];
            if (led_cmd[i] && !r_shadow[i]) begin
                w_flash_next[i] = c_FLASH_LOAD;
            end else if (!led_cmd[i]) begin
                w_flash_next[i] = 8'd0;
            end else if (r_flash_cnt[i] != 8'd0) begin
                w_flash_next[i] = r_flash_cnt[i] - 8'd1;
            end
            w_led_next[i] = r_shadow[i] &&
                            ((r_flash_cnt[i] != 8'd0) ||
                             (r_duty_q == 8'hFF) ||
                             (r_pwm_cnt < r_duty_q));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_cnt     <= '0;
            r_pwm_cnt       <= 8'hFF;
            r_shadow        <= 8'h00;
            r_duty_q        <= 8'h00;
            r_led           <= 8'h00;
            r_period_strobe <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_flash_cnt[i] <= 8'd0;
            end
        end else begin
            r_presc_cnt     <= w_tick ? '0 : r_presc_cnt + 1'b1;
            r_period_strobe <= w_boundary;
            r_led           <= w_led_next;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
            if (w_boundary) begin
                r_shadow <= led_cmd;
                r_duty_q <= duty;
                for (int i = 0; i < 8; i++) begin
                    r_flash_cnt[i] <= w_flash_next[i];
                end
            end
        end
    end

    assign led           = r_led;
    assign period_strobe = r_period_strobe;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pwm_driver
// Brief    : Self-checking bench for led_pwm_driver (PRESCALE=2, FLASH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pwm_driver;

    localparam int c_PERIOD = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] led_cmd = 8'h00;
    logic [7:0] duty = 8'h00;
    logic [7:0] led;
    logic       period_strobe;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt  [8];
    int m_rise [8];
    logic [7:0] ws_led_or;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] duty;
        int         exp_high;
        int         exp_rise;
    } vec_t;

    vec_t vecs [6];

    led_pwm_driver #(
        .PRESCALE      (2),
        .FLASH_PERIODS (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .led_cmd       (led_cmd),
        .duty          (duty),
        .led           (led),
        .period_strobe (period_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns at the negedge sample of the strobe cycle; ORs led while waiting.
    task automatic wait_strobe();
        bit found = 1'b0;
        ws_led_or = 8'h00;
        for (int k = 0; k < 1100 && !found; k++) begin
            @(negedge clk);
            ws_led_or = ws_led_or | led;
            if (period_strobe) found = 1'b1;
        end
        if (!found) check("strobe_timeout", 0, 1);
    endtask

    task automatic measure(input int n);
        logic [7:0] prev = 8'h00;
        for (int b = 0; b < 8; b++) begin
            m_cnt[b]  = 0;
            m_rise[b] = 0;
        end
        repeat (n) begin
            @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                if (led[b]) m_cnt[b]++;
                if (led[b] && !prev[b]) m_rise[b]++;
            end
            prev = led;
        end
    endtask

    // Called at a negedge with reset high; releases it and checks restart timing.
    task automatic restart_check(input string tag, input logic [7:0] exp_led);
        int lat = 0;
        reset = 1'b0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (period_strobe) lat = k;
        end
        check({tag, "_strobe_latency"}, lat, 2);
        check({tag, "_led_at_strobe"}, int'(led), 0);
        @(negedge clk);
        check({tag, "_led_after_strobe"}, int'(led), int'(exp_led));
    endtask

    initial begin
        logic [7:0] or_led;
        logic       or_strobe;

        vecs[0] = '{8'h01, 8'd64,  128, 1};
        vecs[1] = '{8'hFF, 8'd0,   0,   0};
        vecs[2] = '{8'hA5, 8'd128, 256, 1};
        vecs[3] = '{8'h3C, 8'd255, 512, 1};
        vecs[4] = '{8'h81, 8'd1,   2,   1};
        vecs[5] = '{8'h7E, 8'd254, 508, 1};

        // Reset held with active inputs
        led_cmd   = 8'hFF;
        duty      = 8'h80;
        or_led    = 8'h00;
        or_strobe = 1'b0;
        repeat (10) begin
            @(negedge clk);
            or_led    = or_led | led;
            or_strobe = or_strobe | period_strobe;
        end
        check("reset_hold_led", int'(or_led), 0);
        check("reset_hold_strobe", int'(or_strobe), 0);
        restart_check("reset", 8'hFF);

        // Steady-state PWM vectors, measured after any flash has expired
        for (int v = 0; v < 6; v++) begin
            led_cmd = vecs[v].cmd;
            duty    = vecs[v].duty;
            repeat (4) wait_strobe();
            measure(c_PERIOD);
            for (int b = 0; b < 8; b++) begin
                check($sformatf("vec%0d_high_led%0d", v, b), m_cnt[b],
                      vecs[v].cmd[b] ? vecs[v].exp_high : 0);
                check($sformatf("vec%0d_rise_led%0d", v, b), m_rise[b],
                      vecs[v].cmd[b] ? vecs[v].exp_rise : 0);
            end
        end

        // Boundary sync: mid-period command waits for the next load
        led_cmd = 8'h00;
        duty    = 8'd255;
        wait_strobe();
        repeat (256) @(negedge clk);
        led_cmd = 8'h10;
        wait_strobe();
        check("sync_led4_before_load", int'(ws_led_or[4]), 0);
        measure(3 * c_PERIOD);
        check("sync_led4_solid", m_cnt[4], 3 * c_PERIOD);
        check("sync_led4_rises", m_rise[4], 1);

        // Flash, then retrigger after one period off
        led_cmd = 8'h00;
        duty    = 8'd0;
        wait_strobe();
        repeat (100) @(negedge clk);
        led_cmd = 8'h04;
        wait_strobe();
        check("flash_led2_before_load", int'(ws_led_or[2]), 0);
        measure(4 * c_PERIOD);
        check("flash_led2_high", m_cnt[2], 3 * c_PERIOD);
        check("flash_led2_rises", m_rise[2], 1);
        led_cmd = 8'h00;
        wait_strobe();
        led_cmd = 8'h04;
        measure(c_PERIOD);
        check("flash_off_period", m_cnt[2], 0);
        measure(4 * c_PERIOD);
        check("flash_retrigger_high", m_cnt[2], 3 * c_PERIOD);
        check("flash_retrigger_rises", m_rise[2], 1);

        // Duty change mid-period only affects the following period
        led_cmd = 8'h01;
        duty    = 8'd64;
        repeat (4) wait_strobe();
        measure(256);
        check("duty_first_half", m_cnt[0], 128);
        duty = 8'd192;
        measure(256);
        check("duty_second_half", m_cnt[0], 0);
        measure(c_PERIOD);
        check("duty_next_period", m_cnt[0], 384);
        check("duty_next_rises", m_rise[0], 1);

        // Reset in the middle of a flash
        led_cmd = 8'h04;
        duty    = 8'd0;
        wait_strobe();
        repeat (200) @(negedge clk);
        check("midflash_led_before_reset", int'(led), 4);
        reset = 1'b1;
        @(negedge clk);
        check("midflash_reset_led", int'(led), 0);
        check("midflash_reset_strobe", int'(period_strobe), 0);
        restart_check("midflash", 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
